program_fetch_queue: RTL
========================

PROGRAM_FETCH_QUEUE -- requirements
Module: program_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning halfword address width of program memory.
REQ-002 SHALL have parameter DEPTH, default 8, meaning queue capacity in halfwords; power of 2, >=4.
REQ-003 SHALL have parameter MAX_OUT, default 2, meaning maximum outstanding memory requests, 1..3.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  branch redirect; discard queue and in-flight fetches.
REQ-007 flush_addr  input  ADDR_W  halfword target address of redirect.
REQ-008 mem_req  output  1  fetch request valid.
REQ-009 mem_addr  output  ADDR_W-1  32-bit word address of the request.
REQ-010 mem_ready  input  1  request accepted when mem_req & mem_ready.
REQ-011 mem_rvalid  input  1  response valid; responses in request order, one per accepted request, earliest one cycle after acceptance.
REQ-012 mem_rdata  input  32  response; [15:0] lower halfword address, [31:16] upper.
REQ-013 IR_0  output  16  queue head halfword; 16'h0 when ir_count=0.
REQ-014 IR_1  output  16  head+1 halfword; 16'h0 when ir_count<2.
REQ-015 ir_count  output  2  valid halfwords on IR_0/IR_1, min(occupancy,2).
REQ-016 ir_pop  input  2  halfwords consumed this cycle (0,1,2).
REQ-017 wide_0  output  1  IR_0[15:11] in {11101,11110,11111} and ir_count!=0 (32-bit Thumb first half).

Function
REQ-018 Queue SHALL be a DEPTH-entry circular halfword buffer with read/write pointers wrapping modulo DEPTH; IR_0/IR_1/ir_count/wide_0 combinational from registered queue state.
REQ-019 Effective pop SHALL be min(ir_pop, ir_count); excess pop ignored.
REQ-020 mem_req SHALL be high iff not flush and outstanding<MAX_OUT and free slots (after this cycle's effective pop not counted) >= 2*(outstanding+1).
REQ-021 On acceptance, fetch word pointer SHALL increment by 1, wrapping at 2^(ADDR_W-1); mem_addr equals fetch word pointer.
REQ-022 Outstanding counter SHALL increment on acceptance, decrement on mem_rvalid, both same cycle -> unchanged.
REQ-023 Non-discarded response SHALL push both halfwords (low first), or only [31:16] when skip_low set; skip_low then clears.
REQ-024 Push and pop in same cycle SHALL both take effect; response at edge t visible on outputs after edge t.
REQ-025 flush SHALL, at the edge: empty queue, set fetch word pointer to flush_addr[ADDR_W-1:1], set skip_low=flush_addr[0], set discard counter = outstanding minus (1 if mem_rvalid this cycle) plus none (no acceptance in flush cycle); ir_pop and mem_rvalid data in flush cycle are dropped.
REQ-026 While discard counter>0, each mem_rvalid SHALL decrement it and push nothing; outstanding still decrements.
REQ-027 Back-to-back flushes SHALL each take effect; last flush wins; discard counter recomputed from current outstanding.
REQ-028 Queue SHALL never overflow; a response arriving when full is a protocol violation impossible under REQ-020.

Reset
REQ-029 rst SHALL asynchronously clear queue pointers, occupancy, fetch word pointer (0), outstanding, discard counter, skip_low; outputs mem_req=0 while rst high, IR_0=IR_1=0, ir_count=0, wide_0=0.
REQ-030 After rst deassertion SHALL request word 0 on first clock with no flush.
REQ-031 rst mid-operation SHALL discard all state; responses to pre-reset requests are not tracked and the bench does not drive them.

Verification
REQ-032 Reset, mem_ready=1, 1-cycle response, word0=32'h2104_2014, word1=32'h6008_2428, ir_pop=0 -> mem_addr 0,1,2,3 issued then mem_req low at occupancy 8; IR_0=16'h2014, IR_1=16'h2104, ir_count=2.
REQ-033 Steady ir_pop=2 with 1-cycle memory -> IR_0/IR_1 advance by two halfwords every cycle, no bubbles after fill.
REQ-034 flush with flush_addr=14'h5 while 2 requests outstanding -> both responses dropped, next mem_addr=2, only [31:16] of word 2 pushed, IR_0 = halfword 5.
REQ-035 ir_pop=2 with ir_count=1 -> queue empties, ir_count=0, IR_0=16'h0, no underflow.
REQ-036 Head halfword 16'hF000 -> wide_0=1; 16'hE7FE -> wide_0=0.
REQ-037 mem_ready held low 10 cycles -> mem_req held high, mem_addr stable, outstanding unchanged.

Source files
------------

// File: rtl/program_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : program_fetch_queue
// Description : Instruction prefetch queue. Fetches 32-bit words from program
//               memory and presents them as a stream of 16-bit halfwords.
//               It supports branch redirects (flush), and it drops responses
//               to fetches that were already in flight when a flush arrived.
// Ports       : clk, rst (async, active-high)
//               flush / flush_addr      - redirect to a halfword address
//               mem_req / mem_addr      - word fetch request (valid/ready)
//               mem_ready               - request accepted this cycle
//               mem_rvalid / mem_rdata  - in-order fetch responses
//               IR_0 / IR_1 / ir_count  - two head halfwords and how many are valid
//               ir_pop                  - halfwords consumed this cycle
//               wide_0                  - head is the first half of a 32-bit Thumb op
// Revision    : 1.0 - initial release
// ============================================================================
module program_fetch_queue #(
  parameter int ADDR_W  = 14,
  parameter int DEPTH   = 8,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_addr,
  output logic              mem_req,
  output logic [ADDR_W-2:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       IR_0,
  output logic [15:0]       IR_1,
  output logic [1:0]        ir_count,
  input  logic [1:0]        ir_pop,
  output logic              wide_0
);

  localparam int C_PTR_W   = $clog2(DEPTH);
  localparam int C_CNT_W   = C_PTR_W + 1;
  localparam int C_SUM_W   = C_CNT_W + 1;
  localparam int C_WADDR_W = ADDR_W - 1;
  localparam logic [C_SUM_W-1:0] C_DEPTH   = C_SUM_W'(DEPTH);
  localparam logic [1:0]         C_MAX_OUT = 2'(MAX_OUT);

  // Queue storage and state
  logic [15:0]          r_q [DEPTH];
  logic [C_PTR_W-1:0]   r_rd_ptr;
  logic [C_PTR_W-1:0]   r_wr_ptr;
  logic [C_CNT_W-1:0]   r_count;
  logic [C_WADDR_W-1:0] r_fetch_ptr;
  logic [1:0]           r_outstanding;
  logic [1:0]           r_discard;
  logic                 r_skip_low;

  logic [1:0]           w_pop_eff;
  logic [1:0]           w_push_n;
  logic [C_SUM_W-1:0]   w_free;
  logic [C_SUM_W-1:0]   w_need;
  logic                 w_accept;
  logic                 w_live_resp;
  logic                 w_push_lo;

  // Head view of the queue
  assign ir_count = (r_count >= C_CNT_W'(2)) ? 2'd2 : r_count[1:0];
  assign IR_0     = (r_count != '0) ? r_q[r_rd_ptr] : 16'h0;
  assign IR_1     = (r_count >= C_CNT_W'(2)) ? r_q[r_rd_ptr + C_PTR_W'(1)] : 16'h0;
  // Prefixes 11101/11110/11111 mark the first half of a 32-bit encoding
  assign wide_0   = (r_count != '0) && (IR_0[15:13] == 3'b111) && (IR_0[12:11] != 2'b00);

  assign w_pop_eff = (ir_pop > ir_count) ? ir_count : ir_pop;

  // Issue only when room is reserved for every in-flight word plus this one.
  // The pop of the current cycle is ignored, which keeps mem_req off the
  // ir_pop path.
  assign w_free   = C_DEPTH - C_SUM_W'(r_count);
  assign w_need   = C_SUM_W'({r_outstanding, 1'b0}) + C_SUM_W'(2);
  assign mem_req  = !rst && !flush && (r_outstanding < C_MAX_OUT) && (w_free >= w_need);
  assign mem_addr = r_fetch_ptr;
  assign w_accept = mem_req && mem_ready;

  // A response is pushed only if it belongs to the current fetch stream
  assign w_live_resp = mem_rvalid && !flush && (r_discard == 2'd0);
  assign w_push_lo   = w_live_resp && !r_skip_low;
  assign w_push_n    = w_live_resp ? (r_skip_low ? 2'd1 : 2'd2) : 2'd0;

  // Storage needs no reset; ir_count gates every read
  always_ff @(posedge clk) begin
    if (w_push_lo) begin
      r_q[r_wr_ptr]                <= mem_rdata[15:0];
      r_q[r_wr_ptr + C_PTR_W'(1)]  <= mem_rdata[31:16];
    end else if (w_live_resp) begin
      r_q[r_wr_ptr]                <= mem_rdata[31:16];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_fetch_ptr   <= '0;
      r_outstanding <= 2'd0;
      r_discard     <= 2'd0;
      r_skip_low    <= 1'b0;
    end else if (flush) begin
      // Every fetch still in flight after this edge belongs to the old stream
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_fetch_ptr   <= flush_addr[ADDR_W-1:1];
      r_skip_low    <= flush_addr[0];
      r_outstanding <= r_outstanding - {1'b0, mem_rvalid};
      r_discard     <= r_outstanding - {1'b0, mem_rvalid};
    end else begin
      r_rd_ptr      <= r_rd_ptr + C_PTR_W'(w_pop_eff);
      r_wr_ptr      <= r_wr_ptr + C_PTR_W'(w_push_n);
      r_count       <= r_count + C_CNT_W'(w_push_n) - C_CNT_W'(w_pop_eff);
      r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, mem_rvalid};
      if (w_accept) begin
        r_fetch_ptr <= r_fetch_ptr + C_WADDR_W'(1);
      end
      if (mem_rvalid && (r_discard != 2'd0)) begin
        r_discard <= r_discard - 2'd1;
      end
      if (w_live_resp) begin
        r_skip_low <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
